// File: rtl/snn_inference_ctrl.sv
// -----------------------------------------------------------------------------
// snn_inference_ctrl
//   Sequencer for one spiking-neural-network inference. A start request clears
//   the neurons and spike counters for one cycle, enables integration for
//   NUM_STEPS cycles, then scans the NUM_CLASSES spike counters, one per cycle,
//   to find the class with the most spikes. The result is held with done_o
//   until the consumer acknowledges it or starts the next inference.
//
// Ports
//   clk_i          : clock, rising edge
//   rst_ni         : asynchronous active-low reset
//   start_i        : begin an inference (accepted in IDLE and DONE)
//   abort_i        : cancel an inference in CLEAR/RUN/SCAN
//   ack_i          : consumer acknowledge of the result (DONE -> IDLE)
//   spike_counts_i : packed counts, class k at [k*COUNT_W +: COUNT_W]
//   clr_o          : one-cycle clear pulse to neurons/counters
//   run_o          : integration/counting enable
//   busy_o         : inference in progress (CLEAR, RUN, SCAN)
//   done_o         : result valid
//   class_o        : winning class index
//   max_count_o    : spike count of the winning class
// -----------------------------------------------------------------------------
module snn_inference_ctrl #(
    parameter int NUM_STEPS   = 64,
    parameter int NUM_CLASSES = 10,
    parameter int COUNT_W     = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           start_i,
    input  logic                           abort_i,
    input  logic                           ack_i,
    input  logic [NUM_CLASSES*COUNT_W-1:0] spike_counts_i,
    output logic                           clr_o,
    output logic                           run_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic [3:0]                     class_o,
    output logic [COUNT_W-1:0]             max_count_o
);

    localparam logic [7:0] LAST_STEP = 8'(NUM_STEPS - 1);
    localparam logic [3:0] LAST_IDX  = 4'(NUM_CLASSES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_SCAN,
        S_DONE
    } state_e;

    state_e             state_q,    state_d;
    logic [7:0]         step_q,     step_d;
    logic [3:0]         scan_idx_q, scan_idx_d;
    logic [COUNT_W-1:0] run_max_q,  run_max_d;
    logic [3:0]         run_idx_q,  run_idx_d;
    logic [3:0]         class_q,    class_d;
    logic [COUNT_W-1:0] max_q,      max_d;

    logic [COUNT_W-1:0] cur_count;
    logic               cur_gt;
    logic [COUNT_W-1:0] cand_max;
    logic [3:0]         cand_idx;

    // Running-max candidate for the counter addressed this scan cycle. Strictly
    // greater only, so on a tie the earlier (lower) index is kept.
    always_comb begin
        cur_count = spike_counts_i[32'(scan_idx_q) * COUNT_W +: COUNT_W];
        cur_gt    = (cur_count > run_max_q);
        cand_max  = cur_gt ? cur_count : run_max_q;
        cand_idx  = cur_gt ? scan_idx_q : run_idx_q;
    end

    always_comb begin
        // NOTE: every signal gets a hold default first so no path through the
        // case statement leaves it unassigned, which would infer a latch.
        state_d    = state_q;
        step_d     = step_q;
        scan_idx_d = scan_idx_q;
        run_max_d  = run_max_q;
        run_idx_d  = run_idx_q;
        class_d    = class_q;
        max_d      = max_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RUN;
                    step_d  = '0;
                end
            end
            S_RUN: begin
                // Abort wins even on the final RUN cycle.
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (step_q == LAST_STEP) begin
                    state_d    = S_SCAN;
                    scan_idx_d = '0;
                    run_max_d  = '0;
                    run_idx_d  = '0;
                end else begin
                    step_d = step_q + 8'd1;
                end
            end
            S_SCAN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else begin
                    run_max_d = cand_max;
                    run_idx_d = cand_idx;
                    // The published result only changes on a completed scan,
                    // so an abort leaves the previous result visible.
                    if (scan_idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                        class_d = cand_idx;
                        max_d   = cand_max;
                    end else begin
                        scan_idx_d = scan_idx_q + 4'd1;
                    end
                end
            end
            S_DONE: begin
                if (start_i)    state_d = S_CLEAR;
                else if (ack_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            step_q     <= '0;
            scan_idx_q <= '0;
            run_max_q  <= '0;
            run_idx_q  <= '0;
            class_q    <= '0;
            max_q      <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            scan_idx_q <= scan_idx_d;
            run_max_q  <= run_max_d;
            run_idx_q  <= run_idx_d;
            class_q    <= class_d;
            max_q      <= max_d;
        end
    end

    // Pure decodes of the state register: no input reaches these outputs.
    assign clr_o       = (state_q == S_CLEAR);
    assign run_o       = (state_q == S_RUN);
    assign busy_o      = (state_q == S_CLEAR) || (state_q == S_RUN) || (state_q == S_SCAN);
    assign done_o      = (state_q == S_DONE);
    assign class_o     = class_q;
    assign max_count_o = max_q;

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snn_inference_ctrl
//   Directed bench for snn_inference_ctrl with NUM_STEPS=4, NUM_CLASSES=10.
//   Expected results are pushed into a scoreboard queue when an inference is
//   started; a monitor pops and compares on every rising edge of done_o.
//   Cycle-level timing, abort, start/ack interaction and reset are checked
//   directly by the stimulus thread.
// -----------------------------------------------------------------------------
module tb_snn_inference_ctrl;

    localparam int NS = 4;
    localparam int NC = 10;
    localparam int CW = 8;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic           start_i;
    logic           abort_i;
    logic           ack_i;
    logic [NC*CW-1:0] spike_counts_i;
    logic           clr_o, run_o, busy_o, done_o;
    logic [3:0]     class_o;
    logic [CW-1:0]  max_count_o;

    typedef struct {
        logic [3:0]    cls;
        logic [CW-1:0] mx;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic done_prev = 1'b0;

    snn_inference_ctrl #(
        .NUM_STEPS   (NS),
        .NUM_CLASSES (NC),
        .COUNT_W     (CW)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .ack_i          (ack_i),
        .spike_counts_i (spike_counts_i),
        .clr_o          (clr_o),
        .run_o          (run_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .class_o        (class_o),
        .max_count_o    (max_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_all(input logic [CW-1:0] v);
        for (int k = 0; k < NC; k++) spike_counts_i[k*CW +: CW] = v;
    endtask

    task automatic push_exp(input logic [3:0] cls, input logic [CW-1:0] mx);
        exp_t e;
        e.cls = cls;
        e.mx  = mx;
        sb_q.push_back(e);
    endtask

    // Wait (bounded) for done_o, then acknowledge it.
    task automatic wait_done_ack();
        int n = 0;
        while (!done_o && n < 100) begin
            step();
            n++;
        end
        check("done_within_bound", 32'(done_o), 32'd1);
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        check("idle_after_ack", 32'(done_o | busy_o), 32'd0);
    endtask

    // Issue start and check clr/run/done cycle by cycle up to cycle 16.
    // start_i stays high up to cycle hold_until to exercise start-ignore.
    task automatic timed_run(input int hold_until);
        start_i = 1'b1;
        for (int c = 1; c <= NS + NC + 2; c++) begin
            step();
            if (c >= hold_until) start_i = 1'b0;
            check($sformatf("clr_c%0d", c),  32'(clr_o),  32'(c == 1));
            check($sformatf("run_c%0d", c),  32'(run_o),  32'(c >= 2 && c <= NS + 1));
            check($sformatf("done_c%0d", c), 32'(done_o), 32'(c == NS + NC + 2));
        end
    endtask

    // Scoreboard monitor: one expected result per rising edge of done_o.
    always @(negedge clk_i) begin
        if (done_o && !done_prev) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("class_o", 32'(class_o), 32'(e.cls));
                check("max_count_o", 32'(max_count_o), 32'(e.mx));
            end
        end
        done_prev = done_o;
    end

    initial begin
        rst_ni  = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        ack_i   = 1'b0;
        spike_counts_i = '0;

        // Reset state.
        #12;
        check("rst_clr",   32'(clr_o),       32'd0);
        check("rst_run",   32'(run_o),       32'd0);
        check("rst_busy",  32'(busy_o),      32'd0);
        check("rst_done",  32'(done_o),      32'd0);
        check("rst_class", 32'(class_o),     32'd0);
        check("rst_max",   32'(max_count_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();

        // Timing plus tie-to-lower-index: {3,9,2,9,0,...} -> class 1, max 9.
        set_all(8'd0);
        spike_counts_i[0*CW +: CW] = 8'd3;
        spike_counts_i[1*CW +: CW] = 8'd9;
        spike_counts_i[2*CW +: CW] = 8'd2;
        spike_counts_i[3*CW +: CW] = 8'd9;
        push_exp(4'd1, 8'd9);
        timed_run(1);
        step();
        check("done_held",  32'(done_o),  32'd1);
        check("class_held", 32'(class_o), 32'd1);
        wait_done_ack();

        // All-zero counts -> class 0, max 0.
        set_all(8'd0);
        push_exp(4'd0, 8'd0);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        wait_done_ack();

        // Top boundary: count[9]=255, others 254 -> class 9, max 255.
        set_all(8'd254);
        spike_counts_i[9*CW +: CW] = 8'd255;
        push_exp(4'd9, 8'd255);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        wait_done_ack();

        // Abort in the 3rd RUN cycle (cycle 4); no result expected.
        set_all(8'd100);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (3) step();
        check("run_before_abort", 32'(run_o), 32'd1);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        check("abort_run",   32'(run_o),       32'd0);
        check("abort_busy",  32'(busy_o),      32'd0);
        check("abort_done",  32'(done_o),      32'd0);
        check("abort_class", 32'(class_o),     32'd9);
        check("abort_max",   32'(max_count_o), 32'd255);
        repeat (20) step();
        check("abort_stays_idle", 32'(done_o | busy_o), 32'd0);

        // start_i held through RUN: timing unchanged; then start+ack in DONE.
        set_all(8'd0);
        spike_counts_i[0*CW +: CW] = 8'd3;
        spike_counts_i[1*CW +: CW] = 8'd9;
        spike_counts_i[2*CW +: CW] = 8'd2;
        spike_counts_i[3*CW +: CW] = 8'd9;
        push_exp(4'd1, 8'd9);
        timed_run(8);
        push_exp(4'd1, 8'd9);
        start_i = 1'b1;
        ack_i   = 1'b1;
        step();
        start_i = 1'b0;
        ack_i   = 1'b0;
        check("start_ack_clr",  32'(clr_o),  32'd1);
        check("start_ack_done", 32'(done_o), 32'd0);
        wait_done_ack();

        // Asynchronous reset during SCAN (cycle 8).
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (7) step();
        check("in_scan_busy", 32'(busy_o), 32'd1);
        check("in_scan_run",  32'(run_o),  32'd0);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_clr",   32'(clr_o),       32'd0);
        check("arst_run",   32'(run_o),       32'd0);
        check("arst_busy",  32'(busy_o),      32'd0);
        check("arst_done",  32'(done_o),      32'd0);
        check("arst_class", 32'(class_o),     32'd0);
        check("arst_max",   32'(max_count_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        check("post_rst_busy", 32'(busy_o), 32'd0);
        repeat (20) step();
        check("post_rst_idle", 32'(done_o | busy_o), 32'd0);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/snn_inference_ctrl.md
SNN_INFERENCE_CTRL -- requirements
Module: snn_inference_ctrl

Interface
REQ-001 SHALL have parameter NUM_STEPS, default 64, the number of RUN timesteps per inference (range 1..255).
REQ-002 SHALL have parameter NUM_CLASSES, default 10, the number of output neurons/spike counters scanned (range 2..16).
REQ-003 SHALL have parameter COUNT_W, default 8, the width of each spike count.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port start_i, input, 1, the request to begin an inference.
REQ-007 SHALL have port abort_i, input, 1, which cancels an inference in progress.
REQ-008 SHALL have port ack_i, input, 1, the consumer acknowledge of the result.
REQ-009 SHALL have port spike_counts_i, input, NUM_CLASSES*COUNT_W, the packed readout counts; class k occupies bits [k*COUNT_W +: COUNT_W].
REQ-010 SHALL have port clr_o, output, 1, the one-cycle clear pulse to neurons and spike counters.
REQ-011 SHALL have port run_o, output, 1, the enable for neuron integration and spike counting.
REQ-012 SHALL have port busy_o, output, 1, high in every state except IDLE and DONE.
REQ-013 SHALL have port done_o, output, 1, which flags that the result is valid.
REQ-014 SHALL have port class_o, output, 4, the winning class index.
REQ-015 SHALL have port max_count_o, output, COUNT_W, the spike count of the winning class.

Function
REQ-016 SHALL implement a registered FSM with states IDLE, CLEAR, RUN, SCAN, DONE.
REQ-017 SHALL move IDLE->CLEAR when start_i is high in IDLE.
REQ-018 SHALL assert clr_o only in CLEAR, which lasts exactly 1 cycle, then go to RUN.
REQ-019 SHALL assert run_o only in RUN, which lasts exactly NUM_STEPS cycles, counted by a step counter that loads 0 on entry.
REQ-020 SHALL then go to SCAN, which lasts exactly NUM_CLASSES cycles; in scan cycle k it compares count k against a running max.
REQ-021 SHALL update the running max and index only on strictly greater, so ties resolve to the lowest index.
REQ-022 SHALL initialise the running max to 0 and the index to 0 at SCAN entry, so all-zero counts give class_o=0 and max_count_o=0.
REQ-023 SHALL go to DONE after SCAN; done_o is high for the whole of DONE and class_o/max_count_o hold stable.
REQ-024 SHALL leave DONE to IDLE on ack_i; on start_i in DONE it SHALL go directly to CLEAR, and start_i takes priority over ack_i.
REQ-025 SHALL give a latency of NUM_STEPS+NUM_CLASSES+2 cycles from the start_i sample edge to the first done_o cycle.
REQ-026 SHALL ignore start_i while busy_o is high; it is neither queued nor does it restart.
REQ-027 SHALL, on abort_i high in CLEAR, RUN or SCAN, go to IDLE on the next edge, deassert run_o that edge, leave done_o low, and keep class_o/max_count_o at their prior values.
REQ-028 SHALL ignore abort_i in IDLE and DONE.
REQ-029 SHALL give abort_i priority over normal state advance when abort_i and the last RUN or SCAN cycle coincide.
REQ-030 SHALL, when ack_i is high outside DONE, take no action.
REQ-031 SHALL treat spike_counts_i as already registered; it SHALL be sampled only during SCAN, and its values outside SCAN SHALL not affect any output.
REQ-032 SHALL drive clr_o, run_o, busy_o and done_o directly as decodes of registered state, with no combinational path from any input.

Reset
REQ-033 SHALL, while rst_ni is low, immediately force state IDLE, step counter 0, scan index 0, clr_o=0, run_o=0, busy_o=0, done_o=0, class_o=0 and max_count_o=0.
REQ-034 SHALL, on reset asserted mid-inference, discard the inference; after release it SHALL wait in IDLE for a new start_i.

Verification
REQ-035 SHALL verify this scenario with NUM_STEPS=4, NUM_CLASSES=10: start_i pulse at cycle 0 -> clr_o high in cycle 1 only; run_o high in cycles 2-5; done_o rises in cycle 16.
REQ-036 SHALL verify this scenario: counts {3,9,2,9,0,...} -> class_o=1 and max_count_o=9 (tie resolved to the lower index); counts all 0 -> class_o=0 and max_count_o=0.
REQ-037 SHALL verify this scenario: count[9]=255 and all others 254 -> class_o=9 and max_count_o=255.
REQ-038 SHALL verify this scenario: abort_i in the 3rd RUN cycle -> run_o low on the next cycle, state IDLE, done_o stays 0, and previous result unchanged.
REQ-039 SHALL verify this scenario: start_i held high in RUN -> no restart and the cycle count is unchanged; start_i together with ack_i in DONE -> clr_o the next cycle.
REQ-040 SHALL verify this scenario: rst_ni low in SCAN -> all outputs 0 asynchronously, and IDLE after release.
